// File: rtl/piso_serializer_if.sv
// Valid/ready handshake bundle used on both sides of the serializer.
// A transfer happens on a rising clock edge where valid and ready are both 1.
//   data  : payload, DATAWIDTH bits, driven by the master
//   valid : payload valid, driven by the master
//   ready : sink can accept, driven by the slave
interface valid_ready_std_if #(
  parameter int unsigned DATAWIDTH = 8
) ();
  logic [DATAWIDTH-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out width converter.
// Takes IN_WIDTH-bit words on the din slave port and emits them as
// IN_WIDTH/OUT_WIDTH beats on the dout master port, flagging the final beat
// of each word with last. Back-to-back words stream with no idle cycle.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active HIGH (reset when 1)
//   din   : valid_ready_std_if slave,  DATAWIDTH = IN_WIDTH  (parallel words)
//   dout  : valid_ready_std_if master, DATAWIDTH = OUT_WIDTH (serial beats)
//   last  : current dout beat is the final beat of its word
//
// Build option:
//   PISO_LSB_FIRST_EN : when defined, words leave LSB-first (shift right);
//                       otherwise MSB-first (shift left). Handshake, last and
//                       timing are identical in both modes.
//
// IN_WIDTH must be a multiple of OUT_WIDTH with at least two beats per word.
module piso_serializer #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  valid_ready_std_if.slave  din,
  valid_ready_std_if.master dout,
  output logic              last
);

  localparam int unsigned BEATS = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [IN_WIDTH-1:0] sreg, sreg_n;
  logic [CNT_W-1:0]    cnt, cnt_n;

  logic busy;
  logic last_c;
  logic din_ready_c;
  logic beat_xfer_c;
  logic word_xfer_c;

  // Handshake view of the current state
  assign busy        = (state == S_BUSY);
  assign last_c      = busy && (cnt == CNT_W'(BEATS - 1));
  assign beat_xfer_c = busy && dout.ready;
  // Ready early in the last-beat cycle so the next word follows with no bubble
  assign din_ready_c = !busy || (beat_xfer_c && last_c);
  assign word_xfer_c = din.valid && din_ready_c;

  assign din.ready  = din_ready_c;
  assign dout.valid = busy;
  assign last       = last_c;

`ifdef PISO_LSB_FIRST_EN
  assign dout.data = sreg[OUT_WIDTH-1:0];
`else
  assign dout.data = sreg[IN_WIDTH-1 -: OUT_WIDTH];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: load on a word transfer, otherwise advance on a beat transfer
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;

    if (word_xfer_c) begin
      state_n = S_BUSY;
      sreg_n  = din.data;
      cnt_n   = '0;
    end else if (beat_xfer_c) begin
      // Shifting on the last beat too leaves sreg zero once the word is out,
      // so dout.data reads 0 while idle.
`ifdef PISO_LSB_FIRST_EN
      sreg_n = {OUT_WIDTH'(0), sreg[IN_WIDTH-1:OUT_WIDTH]};
`else
      sreg_n = {sreg[IN_WIDTH-OUT_WIDTH-1:0], OUT_WIDTH'(0)};
`endif
      if (last_c) begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer (8 -> 2, four beats per word).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_piso_serializer;

  logic clk;
  logic rst_n;
  logic last;

  int n_vec = 0;
  int n_err = 0;

  valid_ready_std_if #(.DATAWIDTH(8)) din_if ();
  valid_ready_std_if #(.DATAWIDTH(2)) dout_if ();

  piso_serializer #(
    .IN_WIDTH (8),
    .OUT_WIDTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din_if),
    .dout (dout_if),
    .last (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat k (0 = first on the wire) of word w in the configured order.
  // MSB-first: 0xCD -> 11,00,11,01   LSB-first: 0xCD -> 01,11,00,11
  function automatic logic [1:0] exp_beat(input logic [7:0] w, input int k);
    logic [7:0] t;
    t = w;
`ifdef PISO_LSB_FIRST_EN
    return t[2*k +: 2];
`else
    return t[7-2*k -: 2];
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    din_if.valid = 1'b1;
    din_if.data = 8'hCD;
    dout_if.ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if (dout_if.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, dout_if.valid); end
      n_vec++;
      if (last !== 1'b0) begin n_err++; $display("FAIL reset_last cyc%0d got %b exp 0", i, last); end
      n_vec++;
      if (dout_if.data !== 2'b00) begin n_err++; $display("FAIL reset_data cyc%0d got %b exp 00", i, dout_if.data); end
      n_vec++;
      if (din_if.ready !== 1'b1) begin n_err++; $display("FAIL reset_din_ready cyc%0d got %b exp 1", i, din_if.ready); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    din_if.valid = 1'b0;
  endtask

  task automatic test_single_word();
    logic [7:0] got;
    logic [7:0] want;
`ifdef PISO_LSB_FIRST_EN
    want = 8'b01_11_00_11;
`else
    want = 8'b11_00_11_01;
`endif
    got = '0;
    @(negedge clk);
    din_if.data = 8'hCD; din_if.valid = 1'b1; dout_if.ready = 1'b1; #1;
    n_vec++;
    if (din_if.ready !== 1'b1) begin n_err++; $display("FAIL single_din_ready got %b exp 1", din_if.ready); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      din_if.valid = 1'b0; #1;
      got = {got[5:0], dout_if.data};
      n_vec++;
      if (dout_if.valid !== 1'b1) begin n_err++; $display("FAIL single_valid beat%0d got %b exp 1", k, dout_if.valid); end
      n_vec++;
      if (last !== (k == 3)) begin n_err++; $display("FAIL single_last beat%0d got %b exp %b", k, last, (k == 3)); end
    end
    n_vec++;
    if (got !== want) begin n_err++; $display("FAIL single_beats got %b exp %b", got, want); end
    @(negedge clk); #1;
    n_vec++;
    if (dout_if.valid !== 1'b0) begin n_err++; $display("FAIL single_idle_valid got %b exp 0", dout_if.valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    @(negedge clk);
    din_if.data = 8'hCD; din_if.valid = 1'b1; dout_if.ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      w = (c <= 4) ? 8'hCD : 8'h27;
      if (c == 4) din_if.data = 8'h27;
      if (c == 5) din_if.valid = 1'b0;
      #1;
      n_vec++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_beat(w, (c - 1) % 4))
        begin n_err++; $display("FAIL b2b_beat cyc%0d got v=%b d=%b exp v=1 d=%b", c, dout_if.valid, dout_if.data, exp_beat(w, (c - 1) % 4)); end
      n_vec++;
      if (last !== (c == 4 || c == 8)) begin n_err++; $display("FAIL b2b_last cyc%0d got %b exp %b", c, last, (c == 4 || c == 8)); end
      if (c <= 4) begin
        n_vec++;
        if (din_if.ready !== (c == 4)) begin n_err++; $display("FAIL b2b_din_ready cyc%0d got %b exp %b", c, din_if.ready, (c == 4)); end
      end
    end
    @(negedge clk); #1;
    n_vec++;
    if (dout_if.valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle_valid got %b exp 0", dout_if.valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    din_if.data = 8'h27; din_if.valid = 1'b1; dout_if.ready = 1'b1;
    @(negedge clk);
    din_if.valid = 1'b0; #1;
    n_vec++;
    if (dout_if.data !== exp_beat(8'h27, 0)) begin n_err++; $display("FAIL bp_beat0 got %b exp %b", dout_if.data, exp_beat(8'h27, 0)); end
    // Stall on beat 1 with a competing word offered; it must not be taken
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dout_if.ready = 1'b0; din_if.valid = 1'b1; din_if.data = 8'hFF; #1;
      n_vec++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_beat(8'h27, 1) || last !== 1'b0)
        begin n_err++; $display("FAIL bp_hold cyc%0d got v=%b d=%b l=%b exp v=1 d=%b l=0", c, dout_if.valid, dout_if.data, last, exp_beat(8'h27, 1)); end
      n_vec++;
      if (din_if.ready !== 1'b0) begin n_err++; $display("FAIL bp_din_ready cyc%0d got %b exp 0", c, din_if.ready); end
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      dout_if.ready = 1'b1;
      if (k == 3) din_if.valid = 1'b0;
      #1;
      n_vec++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_beat(8'h27, k) || last !== (k == 3))
        begin n_err++; $display("FAIL bp_resume beat%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b", k, dout_if.valid, dout_if.data, last, exp_beat(8'h27, k), (k == 3)); end
    end
    @(negedge clk); #1;
    n_vec++;
    if (dout_if.valid !== 1'b0) begin n_err++; $display("FAIL bp_idle_valid got %b exp 0", dout_if.valid); end
  endtask

  task automatic test_single_cycle_valid();
    logic [7:0] rdy;
    int         bidx [8];
    rdy  = 8'b1100_0110;        // bit c-1 = dout_ready in cycle c: 0,1,1,0,0,0,1,1
    bidx = '{0, 0, 1, 2, 2, 2, 2, 3};
    @(negedge clk);
    din_if.data = 8'hAD; din_if.valid = 1'b1; dout_if.ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      din_if.valid = 1'b0; din_if.data = 8'h55;
      dout_if.ready = rdy[c-1]; #1;
      n_vec++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_beat(8'hAD, bidx[c-1]) || last !== (c == 8))
        begin n_err++; $display("FAIL pulse_beat cyc%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b", c, dout_if.valid, dout_if.data, last, exp_beat(8'hAD, bidx[c-1]), (c == 8)); end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if (dout_if.valid !== 1'b0) begin n_err++; $display("FAIL pulse_no_repeat cyc%0d got %b exp 0", c, dout_if.valid); end
    end
  endtask

  task automatic test_reset_mid_word();
    @(negedge clk);
    din_if.data = 8'hCD; din_if.valid = 1'b1; dout_if.ready = 1'b1;
    @(negedge clk);
    din_if.valid = 1'b0;
    @(negedge clk); #1;
    n_vec++;
    if (dout_if.data !== exp_beat(8'hCD, 1)) begin n_err++; $display("FAIL rstmid_beat1 got %b exp %b", dout_if.data, exp_beat(8'hCD, 1)); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; #1;
    n_vec++;
    if (dout_if.valid !== 1'b0 || last !== 1'b0 || dout_if.data !== 2'b00)
      begin n_err++; $display("FAIL rstmid_flush got v=%b l=%b d=%b exp v=0 l=0 d=00", dout_if.valid, last, dout_if.data); end
    n_vec++;
    if (din_if.ready !== 1'b1) begin n_err++; $display("FAIL rstmid_din_ready got %b exp 1", din_if.ready); end
    din_if.data = 8'h27; din_if.valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      din_if.valid = 1'b0; #1;
      n_vec++;
      if (dout_if.valid !== 1'b1 || dout_if.data !== exp_beat(8'h27, k) || last !== (k == 3))
        begin n_err++; $display("FAIL rstmid_next beat%0d got v=%b d=%b l=%b exp v=1 d=%b l=%b", k, dout_if.valid, dout_if.data, last, exp_beat(8'h27, k), (k == 3)); end
    end
    @(negedge clk); #1;
    n_vec++;
    if (dout_if.valid !== 1'b0) begin n_err++; $display("FAIL rstmid_idle_valid got %b exp 0", dout_if.valid); end
  endtask

  initial begin
    rst_n = 1'b1;
    din_if.valid = 1'b0;
    din_if.data = 8'h00;
    dout_if.ready = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_single_cycle_valid();
    test_reset_mid_word();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
